// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between pipeline requesters, the arbiter and memory.
// slave: arbiter side; master: requesters plus memory model side.
interface mem_port_arbiter_if;
  logic        inst_mem_is_ready;
  logic [31:0] inst_mem_address;
  logic        inst_mem_is_valid;
  logic [31:0] inst_mem_read_data;
  logic        dmem_rd_ready;
  logic        dmem_wr_ready;
  logic [31:0] dmem_address;
  logic [31:0] dmem_write_data;
  logic [3:0]  dmem_write_byte;
  logic        dmem_rd_valid;
  logic [31:0] dmem_read_data;
  logic        dmem_wr_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_error;

  modport slave (
    input  inst_mem_is_ready,
    input  inst_mem_address,
    output inst_mem_is_valid,
    output inst_mem_read_data,
    input  dmem_rd_ready,
    input  dmem_wr_ready,
    input  dmem_address,
    input  dmem_write_data,
    input  dmem_write_byte,
    output dmem_rd_valid,
    output dmem_read_data,
    output dmem_wr_done,
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output mem_wstrb,
    input  mem_ack,
    input  mem_rdata,
    output mem_error
  );

  modport master (
    output inst_mem_is_ready,
    output inst_mem_address,
    input  inst_mem_is_valid,
    input  inst_mem_read_data,
    output dmem_rd_ready,
    output dmem_wr_ready,
    output dmem_address,
    output dmem_write_data,
    output dmem_write_byte,
    input  dmem_rd_valid,
    input  dmem_read_data,
    input  dmem_wr_done,
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  mem_wstrb,
    output mem_ack,
    output mem_rdata,
    input  mem_error
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for one single-ported memory, one access in flight.
// Ports: clk, reset (async active-low), bus (mem_port_arbiter_if.slave).
// Optional fetch-starvation fairness: define MEM_ARB_FAIRNESS_EN.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned STARVE_LIMIT   = 4
) (
  input logic             clk,
  input logic             reset,
  mem_port_arbiter_if.slave bus
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535)
    $error("TIMEOUT_CYCLES out of range");
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15)
    $error("STARVE_LIMIT out of range");

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } state_t;

  state_t      state;
  logic [15:0] tmo_cnt;
  logic        req_r;
  logic        we_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [3:0]  wstrb_r;

  logic d_req;
  logic i_req;
  logic idle;
  logic busy;
  logic expire;
  logic done;
  logic grant_d;
  logic grant_i;

  assign d_req = bus.dmem_wr_ready | bus.dmem_rd_ready;
  assign i_req = bus.inst_mem_is_ready;
  assign idle  = (state == IDLE);
  assign busy  = ~idle;

  // An ack arriving in the expiry cycle completes normally.
  assign expire = busy & ~bus.mem_ack &
                  (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign done   = busy & (bus.mem_ack | expire);

`ifdef MEM_ARB_FAIRNESS_EN
  logic [3:0] starve;
  logic       force_i;

  assign force_i = i_req & (starve == 4'(STARVE_LIMIT));
  assign grant_i = idle & i_req & (~d_req | force_i);
  assign grant_d = idle & d_req & ~grant_i;

  // Counts data grants that overtook a waiting fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve <= 4'd0;
    end else if (grant_i) begin
      starve <= 4'd0;
    end else if (grant_d & i_req) begin
      starve <= starve + 4'd1;
    end
  end
`else
  assign grant_d = idle & d_req;
  assign grant_i = idle & i_req & ~d_req;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      tmo_cnt <= 16'd0;
      req_r   <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= 32'd0;
      wdata_r <= 32'd0;
      wstrb_r <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          tmo_cnt <= 16'd0;
          if (grant_d) begin
            // Write wins over a simultaneous read.
            state   <= BUSY_D;
            req_r   <= 1'b1;
            we_r    <= bus.dmem_wr_ready;
            addr_r  <= bus.dmem_address;
            wdata_r <= bus.dmem_wr_ready ?
                       bus.dmem_write_data : 32'd0;
            wstrb_r <= bus.dmem_wr_ready ?
                       bus.dmem_write_byte : 4'd0;
          end else if (grant_i) begin
            state   <= BUSY_I;
            req_r   <= 1'b1;
            we_r    <= 1'b0;
            addr_r  <= bus.inst_mem_address;
            wdata_r <= 32'd0;
            wstrb_r <= 4'd0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (done) begin
            state   <= IDLE;
            req_r   <= 1'b0;
            we_r    <= 1'b0;
            addr_r  <= 32'd0;
            wdata_r <= 32'd0;
            wstrb_r <= 4'd0;
            tmo_cnt <= 16'd0;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          req_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req   = req_r;
  assign bus.mem_we    = we_r;
  assign bus.mem_addr  = addr_r;
  assign bus.mem_wdata = wdata_r;
  assign bus.mem_wstrb = wstrb_r;
  assign bus.mem_error = expire;

  // Data is passed only on a real ack, so a timeout reads as zero.
  assign bus.inst_mem_is_valid  = (state == BUSY_I) & done;
  assign bus.inst_mem_read_data =
    ((state == BUSY_I) & bus.mem_ack) ? bus.mem_rdata : 32'd0;
  assign bus.dmem_rd_valid  = (state == BUSY_D) & ~we_r & done;
  assign bus.dmem_wr_done   = (state == BUSY_D) & we_r & done;
  assign bus.dmem_read_data =
    ((state == BUSY_D) & ~we_r & bus.mem_ack) ?
    bus.mem_rdata : 32'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Build with MEM_ARB_FAIRNESS_EN to check the fair grant pattern.
module tb_mem_port_arbiter;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .TIMEOUT_CYCLES(8),
    .STARVE_LIMIT(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(string tag);
    chk({tag, "_req"}, 32'(bus.mem_req), 32'd0);
    chk({tag, "_we"}, 32'(bus.mem_we), 32'd0);
    chk({tag, "_addr"}, bus.mem_addr, 32'd0);
    chk({tag, "_wdata"}, bus.mem_wdata, 32'd0);
    chk({tag, "_wstrb"}, 32'(bus.mem_wstrb), 32'd0);
    chk({tag, "_err"}, 32'(bus.mem_error), 32'd0);
    chk({tag, "_ival"}, 32'(bus.inst_mem_is_valid), 32'd0);
    chk({tag, "_idat"}, bus.inst_mem_read_data, 32'd0);
    chk({tag, "_rval"}, 32'(bus.dmem_rd_valid), 32'd0);
    chk({tag, "_rdat"}, bus.dmem_read_data, 32'd0);
    chk({tag, "_wdone"}, 32'(bus.dmem_wr_done), 32'd0);
  endtask

  initial begin
    logic exp_i;
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.inst_mem_is_ready = 1'b0;
    bus.inst_mem_address  = 32'd0;
    bus.dmem_rd_ready     = 1'b0;
    bus.dmem_wr_ready     = 1'b0;
    bus.dmem_address      = 32'd0;
    bus.dmem_write_data   = 32'd0;
    bus.dmem_write_byte   = 4'd0;
    bus.mem_ack           = 1'b0;
    bus.mem_rdata         = 32'd0;

    tick();
    tick();
    chk_idle("rst");
    reset = 1'b1;
    tick();

    // ack in IDLE is ignored
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hA5A5A5A5;
    #1;
    chk_idle("idle_ack");
    tick();
    bus.mem_ack = 1'b0;
    chk("idle_ack_st", 32'(bus.mem_req), 32'd0);

    // 1: fetch only
    bus.inst_mem_is_ready = 1'b1;
    bus.inst_mem_address  = 32'h10;
    tick();
    chk("f1_req", 32'(bus.mem_req), 32'd1);
    chk("f1_addr", bus.mem_addr, 32'h10);
    chk("f1_we", 32'(bus.mem_we), 32'd0);
    chk("f1_wstrb", 32'(bus.mem_wstrb), 32'd0);
    chk("f1_pre", 32'(bus.inst_mem_is_valid), 32'd0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h13;
    #1;
    chk("f1_val", 32'(bus.inst_mem_is_valid), 32'd1);
    chk("f1_data", bus.inst_mem_read_data, 32'h13);
    chk("f1_err", 32'(bus.mem_error), 32'd0);
    tick();
    bus.mem_ack = 1'b0;
    bus.inst_mem_address = 32'h14;
    chk("f1_gap", 32'(bus.mem_req), 32'd0);
    tick();
    chk("f1b_req", 32'(bus.mem_req), 32'd1);
    chk("f1b_addr", bus.mem_addr, 32'h14);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h00000093;
    #1;
    chk("f1b_data", bus.inst_mem_read_data, 32'h93);
    tick();
    bus.mem_ack = 1'b0;
    bus.inst_mem_is_ready = 1'b0;

    // 2: fetch and store together
    tick();
    bus.inst_mem_is_ready = 1'b1;
    bus.inst_mem_address  = 32'h20;
    bus.dmem_wr_ready     = 1'b1;
    bus.dmem_address      = 32'h100;
    bus.dmem_write_data   = 32'hDEADBEEF;
    bus.dmem_write_byte   = 4'hF;
    tick();
    chk("s2_we", 32'(bus.mem_we), 32'd1);
    chk("s2_addr", bus.mem_addr, 32'h100);
    chk("s2_wdata", bus.mem_wdata, 32'hDEADBEEF);
    chk("s2_wstrb", 32'(bus.mem_wstrb), 32'hF);
    bus.mem_ack = 1'b1;
    #1;
    chk("s2_done", 32'(bus.dmem_wr_done), 32'd1);
    chk("s2_ival", 32'(bus.inst_mem_is_valid), 32'd0);
    tick();
    bus.mem_ack = 1'b0;
    bus.dmem_wr_ready = 1'b0;
    chk("s2_gap", 32'(bus.mem_req), 32'd0);
    tick();
    chk("s2_freq", 32'(bus.mem_req), 32'd1);
    chk("s2_faddr", bus.mem_addr, 32'h20);
    chk("s2_fwe", 32'(bus.mem_we), 32'd0);
    chk("s2_fstrb", 32'(bus.mem_wstrb), 32'd0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h55;
    #1;
    chk("s2_fval", 32'(bus.inst_mem_is_valid), 32'd1);
    tick();
    bus.mem_ack = 1'b0;
    bus.inst_mem_is_ready = 1'b0;

    // 3: read and write together
    tick();
    bus.dmem_rd_ready   = 1'b1;
    bus.dmem_wr_ready   = 1'b1;
    bus.dmem_address    = 32'h200;
    bus.dmem_write_data = 32'h11223344;
    bus.dmem_write_byte = 4'h3;
    tick();
    chk("rw3_we", 32'(bus.mem_we), 32'd1);
    chk("rw3_wstrb", 32'(bus.mem_wstrb), 32'h3);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hFFFF0000;
    #1;
    chk("rw3_wdone", 32'(bus.dmem_wr_done), 32'd1);
    chk("rw3_rval0", 32'(bus.dmem_rd_valid), 32'd0);
    tick();
    bus.mem_ack = 1'b0;
    bus.dmem_wr_ready = 1'b0;
    tick();
    chk("rw3_rreq", 32'(bus.mem_req), 32'd1);
    chk("rw3_rwe", 32'(bus.mem_we), 32'd0);
    chk("rw3_raddr", bus.mem_addr, 32'h200);
    chk("rw3_rstrb", 32'(bus.mem_wstrb), 32'd0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hCAFEF00D;
    #1;
    chk("rw3_rval", 32'(bus.dmem_rd_valid), 32'd1);
    chk("rw3_rdat", bus.dmem_read_data, 32'hCAFEF00D);
    chk("rw3_wd0", 32'(bus.dmem_wr_done), 32'd0);
    tick();
    bus.mem_ack = 1'b0;
    bus.dmem_rd_ready = 1'b0;

    // 4: timeout after 8 busy cycles
    tick();
    bus.dmem_rd_ready = 1'b1;
    bus.dmem_address  = 32'h300;
    bus.mem_rdata     = 32'hFFFFFFFF;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("to4_req", 32'(bus.mem_req), 32'd1);
      chk("to4_err0", 32'(bus.mem_error), 32'd0);
      chk("to4_val0", 32'(bus.dmem_rd_valid), 32'd0);
    end
    tick();
    chk("to4_err", 32'(bus.mem_error), 32'd1);
    chk("to4_val", 32'(bus.dmem_rd_valid), 32'd1);
    chk("to4_dat", bus.dmem_read_data, 32'd0);
    tick();
    bus.dmem_rd_ready = 1'b0;
    chk("to4_idle", 32'(bus.mem_req), 32'd0);
    chk("to4_err1", 32'(bus.mem_error), 32'd0);
    bus.inst_mem_is_ready = 1'b1;
    bus.inst_mem_address  = 32'h40;
    tick();
    chk("to4_nreq", 32'(bus.mem_req), 32'd1);
    chk("to4_naddr", bus.mem_addr, 32'h40);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h77;
    #1;
    chk("to4_nval", 32'(bus.inst_mem_is_valid), 32'd1);
    chk("to4_ndat", bus.inst_mem_read_data, 32'h77);
    tick();
    bus.mem_ack = 1'b0;
    bus.inst_mem_is_ready = 1'b0;

    // ack in the expiry cycle wins over the timeout
    tick();
    bus.dmem_rd_ready = 1'b1;
    bus.dmem_address  = 32'h304;
    for (int k = 1; k <= 8; k++) tick();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h12345678;
    #1;
    chk("tw_err", 32'(bus.mem_error), 32'd0);
    chk("tw_val", 32'(bus.dmem_rd_valid), 32'd1);
    chk("tw_dat", bus.dmem_read_data, 32'h12345678);
    tick();
    bus.mem_ack = 1'b0;
    bus.dmem_rd_ready = 1'b0;

    // 5: async reset during a data access
    tick();
    bus.dmem_wr_ready   = 1'b1;
    bus.dmem_address    = 32'h500;
    bus.dmem_write_data = 32'h0BADF00D;
    bus.dmem_write_byte = 4'h1;
    tick();
    chk("r5_req", 32'(bus.mem_req), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("r5_drop", 32'(bus.mem_req), 32'd0);
    chk("r5_wd", 32'(bus.dmem_wr_done), 32'd0);
    bus.dmem_wr_ready = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk_idle("r5_post");

    // 6: data always requesting, fetch pending
    bus.inst_mem_is_ready = 1'b1;
    bus.inst_mem_address  = 32'h44;
    bus.dmem_rd_ready     = 1'b1;
    bus.dmem_address      = 32'h400;
    bus.mem_rdata         = 32'h66;
    for (int g = 0; g < 6; g++) begin
`ifdef MEM_ARB_FAIRNESS_EN
      exp_i = ((g % 3) == 2);
`else
      exp_i = 1'b0;
`endif
      tick();
      chk("g6_req", 32'(bus.mem_req), 32'd1);
      chk("g6_addr", bus.mem_addr,
          exp_i ? 32'h44 : 32'h400);
      bus.mem_ack = 1'b1;
      #1;
      chk("g6_ival", 32'(bus.inst_mem_is_valid),
          32'(exp_i));
      chk("g6_rval", 32'(bus.dmem_rd_valid),
          32'(!exp_i));
      tick();
      bus.mem_ack = 1'b0;
    end
    bus.inst_mem_is_ready = 1'b0;
    bus.dmem_rd_ready     = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
